seg_scan_hex595: RTL and testbench
==================================

Name: seg_scan_hex595

Overview:
Parametrised successor to the 4-byte hex 595 display driver. It drives a serial 74HC595 chain (segment byte plus digit-select field) as a multiplexed NUM_DIGITS hex display. Per-digit decimal points, blank mask, leading-zero suppression, enable/blank-all, and tear-free snapshotting are added. It sits at the top level beside the USB/SDRAM/VGA blocks and shows debug bytes.

Parameters:
NUM_DIGITS, 8, number of hex digits scanned (1..16); digit 0 = data[3:0]
SEL_BITS, 8, width of the digit-select field in the chain (>= NUM_DIGITS)
CLK_DIV, 4, sys_clk cycles per shift-clock half-period (>= 1)
DWELL, 2000, sys_clk cycles a digit stays latched before the next frame starts (>= 0)
SEG_ACTIVE_LOW, 1, 1 = segment bits inverted on the wire
SEL_ACTIVE_LOW, 1, 1 = select bits inverted on the wire

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous active-low reset
enable  in  1  0 = shift all-off frames
lzs  in  1  leading-zero suppression enable
data  in  4*NUM_DIGITS  hex nibbles
dp  in  NUM_DIGITS  decimal point per digit
blank  in  NUM_DIGITS  force digit off
seg_clk  out  1  595 shift clock
seg_dat  out  1  595 serial data
seg_str  out  1  595 storage strobe
digit_idx  out  4  digit in current frame
frame_done  out  1  one-cycle pulse after each strobe ends

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge): seg_clk/seg_dat/seg_str/frame_done=0, digit_idx=0, state=LOAD. Reset mid-shift aborts the frame. The scan restarts at digit 0 on the first cycle after release.
- FRAME_BITS = 8+SEL_BITS. The frame word is {seg[7:0], sel[SEL_BITS-1:0]}, shifted MSB first.
- seg = {dp,g,f,e,d,c,b,a}, active-high before polarity. Hex table: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Invert if SEG_ACTIVE_LOW.
- sel is one-hot bit digit_idx (bits >= NUM_DIGITS are 0), inverted if SEL_ACTIVE_LOW.
- Off state: seg=0 and sel=0 before polarity.
- State LOAD (1 cycle):
  - If digit_idx==0, snapshot data/dp/blank/lzs into shadow registers. All decoding uses the shadows, so a mid-scan input change appears only from the next digit-0 frame.
  - Build the frame word into the shift register. bit counter=FRAME_BITS-1.
  - Go to SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles): seg_clk=0, seg_dat=current MSB. Go to SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles): seg_clk=1. At exit, shift left and decrement the counter. Go to SHIFT_LO, or to LATCH after the last bit.
- LATCH (CLK_DIV cycles): seg_clk=0, seg_str=1. At exit seg_str=0 and frame_done pulses for 1 cycle. Go to DWELL.
- DWELL (DWELL cycles, 0 = skip): digit_idx advances at exit, wrapping NUM_DIGITS-1 -> 0. Go to LOAD.
- Timing: first seg_str rise = 1+FRAME_BITS*2*CLK_DIV cycles after reset release. Frame period = 1+FRAME_BITS*2*CLK_DIV+CLK_DIV+DWELL.
- Digit is off when any of these holds: blank[i]; enable=0 (sampled at LOAD; select also off); or lzs is set, data nibble i is 0, dp[i]=0, and all higher digits are suppressed. Digit 0 is never suppressed by lzs.
- seg_dat is held stable for the whole HI phase; seg_str never overlaps seg_clk=1.
- All counters are sized by $clog2 and saturate-free; no combinational paths from inputs to outputs.

Decomposition:
- Package seg595_pkg holds:
  - hex-to-segment constant table and decode function
  - segment bit-position constants
  - state enum {LOAD, SHIFT_LO, SHIFT_HI, LATCH, DWELL}
- One sub-module, seg595_shifter:
  - parallel load of FRAME_BITS, CLK_DIV timing, clk/dat/str generation, done pulse
  - the top handles snapshot, suppression, decode and scan index.

Test Plan:
1. NUM_DIGITS=8, SEL_BITS=8, CLK_DIV=2, DWELL=10, data=32'h00000001, lzs=0 -> first strobe rises at cycle 65. Captured word is 0xF9FE (seg '1' active-low, sel digit0). Strobe is high 2 cycles, then frame_done pulses.
2. data=32'h00000120, lzs=1 -> seg bytes digits 0..7: C0, A4, F9, then FF x5. dp[5]=1 -> digit5 shows 0x40 (dp plus '0').
3. Change data from 0x11111111 to 0x22222222 while digit_idx=3 -> digits 3..7 still show '1'. The next digit-0 frame shows '2'.
4. Assert sys_rst_n=0 during bit 7 of a frame -> next cycle all outputs 0, digit_idx=0. After release, a full frame is shifted for digit 0.
5. CLK_DIV=1, DWELL=0 -> frame period 34 cycles. digit_idx wraps 7->0, and frame_done pulses every 34 cycles.
6. enable=0 -> every frame word is 0xFFFF. blank=8'h01 with enable=1 -> digit0 frame word is 0xFFFE.

Source files
------------

// File: rtl/seg595_pkg.sv
// Shared definitions for the multiplexed hex display driver that feeds a
// 74HC595 chain: segment bit positions, the hex-to-segment table and the
// frame sequencer state encoding.
package seg595_pkg;

  // Segment byte layout, active-high before wire polarity: {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_DWELL
  } state_e;

  // Returns segments a..g (bit SEG_A..SEG_G) for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg595_shifter.sv
// Frame sequencer and serialiser for a 74HC595 chain.
// Ports:
//   clk, rst_n    : system clock, synchronous active-low reset
//   frame_i       : frame word, captured while load_o is high
//   load_o        : high during the single LOAD cycle
//   adv_o         : one-cycle pulse when the dwell ends (advance digit)
//   seg_clk/seg_dat/seg_str : registered 595 shift clock, data, strobe
//   frame_done    : one-cycle pulse after the strobe falls
module seg595_shifter
  import seg595_pkg::*;
#(
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 4,
  parameter int DWELL      = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FRAME_BITS-1:0] frame_i,
  output logic                  load_o,
  output logic                  adv_o,
  output logic                  seg_clk,
  output logic                  seg_dat,
  output logic                  seg_str,
  output logic                  frame_done
);

  localparam int TMR_MAX = (CLK_DIV > DWELL) ? CLK_DIV : DWELL;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS);
  localparam logic [TMR_W-1:0] DIV_LAST   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] DWELL_LAST = TMR_W'((DWELL > 0) ? DWELL - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  seg_clk_q, seg_clk_d;
  logic                  seg_dat_q, seg_dat_d;
  logic                  seg_str_q, seg_str_d;
  logic                  frame_done_q, frame_done_d;
  logic                  adv;
  logic                  tmr_done;

  // State register (control state is reset; the shift register is reloaded
  // on every LOAD so it needs none).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      tmr_q        <= '0;
      bit_q        <= '0;
      seg_clk_q    <= 1'b0;
      seg_dat_q    <= 1'b0;
      seg_str_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      bit_q        <= bit_d;
      seg_clk_q    <= seg_clk_d;
      seg_dat_q    <= seg_dat_d;
      seg_str_q    <= seg_str_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  // Next-state logic; every timed phase counts its timer down to zero.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    adv      = 1'b0;
    tmr_done = (tmr_q == '0);
    case (state_q)
      ST_LOAD: begin
        sr_d    = frame_i;
        bit_d   = BIT_LAST;
        tmr_d   = DIV_LAST;
        state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (tmr_done) begin
          tmr_d   = DIV_LAST;
          state_d = ST_SHIFT_HI;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (tmr_done) begin
          sr_d  = sr_q << 1;
          tmr_d = DIV_LAST;
          if (bit_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = ST_SHIFT_LO;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_LATCH: begin
        if (tmr_done) begin
          if (DWELL == 0) begin
            adv     = 1'b1;
            state_d = ST_LOAD;
          end else begin
            tmr_d   = DWELL_LAST;
            state_d = ST_DWELL;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_DWELL: begin
        if (tmr_done) begin
          adv     = 1'b1;
          state_d = ST_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Outputs are registered from the next state so they change in step with
  // the phase they belong to; data only moves when the clock is low.
  always_comb begin
    seg_clk_d    = (state_d == ST_SHIFT_HI);
    seg_str_d    = (state_d == ST_LATCH);
    frame_done_d = (state_q == ST_LATCH) && (state_d != ST_LATCH);
    seg_dat_d    = seg_dat_q;
    if (state_d == ST_SHIFT_LO || state_d == ST_SHIFT_HI) begin
      seg_dat_d = sr_d[FRAME_BITS-1];
    end
  end

  assign load_o     = (state_q == ST_LOAD);
  assign adv_o      = adv;
  assign seg_clk    = seg_clk_q;
  assign seg_dat    = seg_dat_q;
  assign seg_str    = seg_str_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/seg_scan_hex595.sv
// Multiplexed NUM_DIGITS hex display driver over a serial 74HC595 chain.
// Each frame carries {segment byte, digit-select field}, MSB first.
// Ports:
//   sys_clk, sys_rst_n : system clock, synchronous active-low reset
//   enable             : 0 = all-off frames (segments and select off)
//   lzs                : leading-zero suppression
//   data/dp/blank      : hex nibbles, decimal points, per-digit blank
//   seg_clk/seg_dat/seg_str : 595 shift clock, serial data, storage strobe
//   digit_idx          : digit carried by the current frame
//   frame_done         : one-cycle pulse after each strobe
module seg_scan_hex595
  import seg595_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SEL_BITS       = 8,
  parameter int CLK_DIV        = 4,
  parameter int DWELL          = 2000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    enable,
  input  logic                    lzs,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic                    seg_clk,
  output logic                    seg_dat,
  output logic                    seg_str,
  output logic [3:0]              digit_idx,
  output logic                    frame_done
);

  localparam int FRAME_BITS = 8 + SEL_BITS;
  localparam logic [7:0]          SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [SEL_BITS-1:0] SEL_POL = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic                    lzs_sh_q, lzs_sh_d;
  logic [3:0]              digit_idx_q, digit_idx_d;
  logic                    load, adv;
  logic [FRAME_BITS-1:0]   frame;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      digit_idx_q <= '0;
    end else begin
      digit_idx_q <= digit_idx_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    data_sh_q  <= data_sh_d;
    dp_sh_q    <= dp_sh_d;
    blank_sh_q <= blank_sh_d;
    lzs_sh_q   <= lzs_sh_d;
  end

  // Shadows refresh only at the digit-0 LOAD so a scan never mixes two input
  // snapshots. The *_d values are what the frame being loaded must show.
  always_comb begin
    data_sh_d  = data_sh_q;
    dp_sh_d    = dp_sh_q;
    blank_sh_d = blank_sh_q;
    lzs_sh_d   = lzs_sh_q;
    if (load && digit_idx_q == 4'd0) begin
      data_sh_d  = data;
      dp_sh_d    = dp;
      blank_sh_d = blank;
      lzs_sh_d   = lzs;
    end
    digit_idx_d = digit_idx_q;
    if (adv) begin
      digit_idx_d = (digit_idx_q == 4'(NUM_DIGITS - 1)) ? 4'd0 : digit_idx_q + 4'd1;
    end
  end

  logic [NUM_DIGITS-1:0] sup;
  logic                  sup_run;
  logic [3:0]            nib;
  logic                  cur_dp;
  logic                  cur_off;
  logic [7:0]            seg_raw;
  logic [SEL_BITS-1:0]   sel_raw;

  always_comb begin
    // Suppression runs down from the top digit and stops at the first digit
    // that has a non-zero nibble or a lit decimal point; digit 0 never blanks.
    sup     = '0;
    sup_run = lzs_sh_d;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      sup_run = sup_run && (data_sh_d[4*i +: 4] == 4'd0) && !dp_sh_d[i];
      sup[i]  = sup_run;
    end
    nib     = '0;
    cur_dp  = 1'b0;
    cur_off = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == 4'(i)) begin
        nib     = data_sh_d[4*i +: 4];
        cur_dp  = dp_sh_d[i];
        cur_off = blank_sh_d[i] || sup[i];
      end
    end
    seg_raw = {cur_dp, hex_to_seg(nib)};
    if (!enable || cur_off) begin
      seg_raw = 8'h00;
    end
    // Blanked or suppressed digits keep their select; only enable drops it.
    sel_raw = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_raw[i] = enable && (digit_idx_q == 4'(i));
    end
    frame = {seg_raw ^ SEG_POL, sel_raw ^ SEL_POL};
  end

  seg595_shifter #(
    .FRAME_BITS(FRAME_BITS),
    .CLK_DIV   (CLK_DIV),
    .DWELL     (DWELL)
  ) u_shifter (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .frame_i   (frame),
    .load_o    (load),
    .adv_o     (adv),
    .seg_clk   (seg_clk),
    .seg_dat   (seg_dat),
    .seg_str   (seg_str),
    .frame_done(frame_done)
  );

  assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg_scan_hex595.sv
module tb_seg_scan_hex595;

  typedef struct {
    logic [15:0] word;
    logic [3:0]  idx;
    int          nbits;
  } frame_t;

  localparam logic [6:0] SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        lzs = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  blank = '0;

  logic       a_clk, a_dat, a_str, a_fd;
  logic [3:0] a_idx;
  logic       b_clk, b_dat, b_str, b_fd;
  logic [3:0] b_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_hex595 #(.NUM_DIGITS(8), .SEL_BITS(8), .CLK_DIV(2), .DWELL(10),
                    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable), .lzs(lzs), .data(data),
    .dp(dp), .blank(blank), .seg_clk(a_clk), .seg_dat(a_dat), .seg_str(a_str),
    .digit_idx(a_idx), .frame_done(a_fd));

  seg_scan_hex595 #(.NUM_DIGITS(8), .SEL_BITS(8), .CLK_DIV(1), .DWELL(0),
                    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(enable), .lzs(lzs), .data(data),
    .dp(dp), .blank(blank), .seg_clk(b_clk), .seg_dat(b_dat), .seg_str(b_str),
    .digit_idx(b_idx), .frame_done(b_fd));

  // Wire-level monitor: rebuilds frames from seg_clk rises, closes a frame on
  // each strobe rise, and records frame_done times and protocol violations.
  frame_t     qa[$];
  frame_t     qb[$];
  int         fda[$];
  int         fdb[$];
  int         cyc = 0;
  int         overlap = 0;
  int         glitch = 0;
  logic [15:0] sh[2];
  int         bcnt[2];
  logic       pclk[2], pstr[2], pdat[2];
  logic       mc[2], md[2], ms[2], mf[2];
  logic [3:0] mi[2];

  always @(negedge clk) begin
    frame_t f;
    cyc++;
    mc[0] = a_clk; md[0] = a_dat; ms[0] = a_str; mf[0] = a_fd; mi[0] = a_idx;
    mc[1] = b_clk; md[1] = b_dat; ms[1] = b_str; mf[1] = b_fd; mi[1] = b_idx;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        bcnt[k] = 0; pclk[k] = 1'b0; pstr[k] = 1'b0; pdat[k] = 1'b0; sh[k] = '0;
      end else begin
        if (mc[k] && ms[k]) overlap++;
        if (mc[k] && pclk[k] && md[k] !== pdat[k]) glitch++;
        if (mc[k] && !pclk[k]) begin
          sh[k] = {sh[k][14:0], md[k]};
          bcnt[k]++;
        end
        if (ms[k] && !pstr[k]) begin
          f.word = sh[k]; f.idx = mi[k]; f.nbits = bcnt[k];
          if (k == 0) qa.push_back(f); else qb.push_back(f);
          bcnt[k] = 0;
        end
        if (mf[k]) begin
          if (k == 0) fda.push_back(cyc); else fdb.push_back(cyc);
        end
        pclk[k] = mc[k]; pstr[k] = ms[k]; pdat[k] = md[k];
      end
    end
  end

  // Reference: the leading digit is the highest one with a non-zero nibble or
  // a lit point; with lzs every digit above it is dark.
  function automatic logic [15:0] model_word(input logic [31:0] d, input logic [7:0] p,
                                             input logic [7:0] b, input logic z,
                                             input logic e, input int idx);
    int         lead = 0;
    logic [7:0] s;
    logic [7:0] sl;
    for (int i = 0; i < 8; i++) if (d[4*i +: 4] != 4'd0 || p[i]) lead = i;
    s = {p[idx], SEGTAB[d[4*idx +: 4]]};
    if (!e || b[idx] || (z && idx > lead)) s = 8'h00;
    sl = e ? (8'h01 << idx) : 8'h00;
    return {~s, ~sl};
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    qa.delete(); qb.delete(); fda.delete(); fdb.delete();
  endtask

  task automatic wait_frames(input int which, input int n, output bit ok);
    int c = 0;
    while (((which == 0) ? qa.size() : qb.size()) < n && c < 5000) begin
      @(negedge clk);
      c++;
    end
    ok = ((which == 0) ? qa.size() : qb.size()) >= n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_clk !== 1'b0) begin n_fail++; $display("FAIL reset_seg_clk got=%b want=0", a_clk); end
    n_checks++; if (a_dat !== 1'b0) begin n_fail++; $display("FAIL reset_seg_dat got=%b want=0", a_dat); end
    n_checks++; if (a_str !== 1'b0) begin n_fail++; $display("FAIL reset_seg_str got=%b want=0", a_str); end
    n_checks++; if (a_fd !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b want=0", a_fd); end
    n_checks++; if (a_idx !== 4'd0) begin n_fail++; $display("FAIL reset_digit_idx got=%0d want=0", a_idx); end
    n_checks++; if (b_str !== 1'b0 || b_idx !== 4'd0) begin n_fail++; $display("FAIL reset_b got str=%b idx=%0d want 0/0", b_str, b_idx); end
  endtask

  task automatic test_first_strobe();
    int fa = 0, fb = 0, hi = 0, fdc = 0;
    enable = 1'b1; lzs = 1'b0; data = 32'h00000001; dp = '0; blank = '0;
    reset_dut();
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (a_str) begin if (fa == 0) fa = c; hi++; end
      if (b_str && fb == 0) fb = c;
      if (a_fd && fdc == 0) fdc = c;
    end
    n_checks++; if (fa != 65) begin n_fail++; $display("FAIL first_strobe_a got=%0d want=65", fa); end
    n_checks++; if (fb != 33) begin n_fail++; $display("FAIL first_strobe_b got=%0d want=33", fb); end
    n_checks++; if (hi != 2) begin n_fail++; $display("FAIL strobe_width got=%0d want=2", hi); end
    n_checks++; if (fdc != 67) begin n_fail++; $display("FAIL frame_done_cycle got=%0d want=67", fdc); end
    n_checks++;
    if (qa.size() < 1) begin n_fail++; $display("FAIL first_word got=none want=f9fe"); end
    else if (qa[0].word !== 16'hF9FE || qa[0].idx !== 4'd0 || qa[0].nbits != 16) begin
      n_fail++; $display("FAIL first_word got=%h idx=%0d bits=%0d want=f9fe idx=0 bits=16",
                         qa[0].word, qa[0].idx, qa[0].nbits);
    end
  endtask

  task automatic test_lzs();
    logic [7:0] exp0 [8] = '{8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp1 [8] = '{8'hC0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'h40, 8'hFF, 8'hFF};
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      enable = 1'b1; lzs = 1'b1; data = 32'h00000120; blank = '0;
      dp = (pass == 0) ? 8'h00 : 8'h20;
      reset_dut();
      wait_frames(0, 8, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL lzs_timeout got=%0d want=8 frames", qa.size()); end
      else begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] want;
          want = (pass == 0) ? exp0[i] : exp1[i];
          n_checks++;
          if (qa[i].word[15:8] !== want || qa[i].idx !== 4'(i)) begin
            n_fail++; $display("FAIL lzs_p%0d_d%0d got=%h idx=%0d want=%h idx=%0d",
                               pass, i, qa[i].word[15:8], qa[i].idx, want, i);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 4; it++) begin
      enable = 1'b1;
      lzs    = 1'($urandom);
      data   = $urandom >> (4 * $urandom_range(0, 7));
      dp     = 8'($urandom & $urandom & $urandom);
      blank  = 8'($urandom & $urandom);
      reset_dut();
      wait_frames(0, 8, ok);
      n_checks++;
      if (!ok || qb.size() < 8) begin n_fail++; $display("FAIL rand_timeout got=%0d/%0d want=8", qa.size(), qb.size()); end
      else begin
        for (int i = 0; i < 8; i++) begin
          logic [15:0] w;
          w = model_word(data, dp, blank, lzs, 1'b1, i);
          n_checks++;
          if (qa[i].word !== w || qa[i].idx !== 4'(i) || qa[i].nbits != 16) begin
            n_fail++; $display("FAIL rand_a_%0d_%0d got=%h idx=%0d want=%h idx=%0d", it, i, qa[i].word, qa[i].idx, w, i);
          end
          n_checks++;
          if (qb[i].word !== w || qb[i].idx !== 4'(i)) begin
            n_fail++; $display("FAIL rand_b_%0d_%0d got=%h idx=%0d want=%h idx=%0d", it, i, qb[i].word, qb[i].idx, w, i);
          end
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int c = 0;
    bit ok;
    enable = 1'b1; lzs = 1'b0; dp = '0; blank = '0; data = 32'h11111111;
    reset_dut();
    while (a_idx !== 4'd3 && c < 2000) begin @(negedge clk); c++; end
    n_checks++;
    if (a_idx !== 4'd3) begin n_fail++; $display("FAIL snap_reach_idx3 got=%0d want=3", a_idx); end
    data = 32'h22222222;
    qa.delete();
    wait_frames(0, 6, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL snap_timeout got=%0d want=6 frames", qa.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        logic [15:0] w;
        int          d;
        d = (i < 5) ? i + 3 : 0;
        w = (i < 5) ? model_word(32'h11111111, 8'h00, 8'h00, 1'b0, 1'b1, d)
                    : model_word(32'h22222222, 8'h00, 8'h00, 1'b0, 1'b1, d);
        n_checks++;
        if (qa[i].word !== w || qa[i].idx !== 4'(d)) begin
          n_fail++; $display("FAIL snap_%0d got=%h idx=%0d want=%h idx=%0d", i, qa[i].word, qa[i].idx, w, d);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    bit ok;
    enable = 1'b1; lzs = 1'b0; dp = '0; blank = '0; data = $urandom;
    reset_dut();
    while (!(a_idx == 4'd2 && bcnt[0] == 8) && c < 3000) begin @(negedge clk); c++; end
    n_checks++;
    if (!(a_idx == 4'd2 && bcnt[0] == 8)) begin n_fail++; $display("FAIL mid_reach got idx=%0d bits=%0d want 2/8", a_idx, bcnt[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_clk, a_dat, a_str, a_fd} !== 4'b0000 || a_idx !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs got=%b idx=%0d want=0000 idx=0", {a_clk, a_dat, a_str, a_fd}, a_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete(); qb.delete(); fda.delete(); fdb.delete();
    wait_frames(0, 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mid_restart_timeout got=0 want=1 frame"); end
    else if (qa[0].idx !== 4'd0 || qa[0].nbits != 16 || qa[0].word !== model_word(data, dp, blank, lzs, 1'b1, 0)) begin
      n_fail++; $display("FAIL mid_restart got=%h idx=%0d bits=%0d want=%h idx=0 bits=16",
                         qa[0].word, qa[0].idx, qa[0].nbits, model_word(data, dp, blank, lzs, 1'b1, 0));
    end
  endtask

  task automatic test_period();
    bit ok;
    enable = 1'b1; lzs = 1'b0; dp = '0; blank = '0; data = $urandom;
    reset_dut();
    wait_frames(1, 11, ok);
    n_checks++;
    if (!ok || fdb.size() < 10 || fda.size() < 3) begin
      n_fail++; $display("FAIL period_timeout got=%0d/%0d want=10/3", fdb.size(), fda.size());
    end else begin
      for (int i = 1; i < 10; i++) begin
        n_checks++;
        if (fdb[i] - fdb[i-1] != 34) begin n_fail++; $display("FAIL period_b_%0d got=%0d want=34", i, fdb[i] - fdb[i-1]); end
      end
      n_checks++;
      if (fda[2] - fda[1] != 77) begin n_fail++; $display("FAIL period_a got=%0d want=77", fda[2] - fda[1]); end
      for (int i = 0; i < 11; i++) begin
        n_checks++;
        if (qb[i].idx !== 4'(i % 8)) begin n_fail++; $display("FAIL wrap_%0d got=%0d want=%0d", i, qb[i].idx, i % 8); end
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    enable = 1'b0; lzs = 1'b0; dp = 8'($urandom); blank = '0; data = $urandom;
    reset_dut();
    wait_frames(0, 8, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL en_timeout got=%0d want=8", qa.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (qa[i].word !== 16'hFFFF) begin n_fail++; $display("FAIL enable_off_%0d got=%h want=ffff", i, qa[i].word); end
      end
    end
    enable = 1'b1; blank = 8'h01;
    reset_dut();
    wait_frames(0, 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL blank_timeout got=0 want=1"); end
    else if (qa[0].word !== 16'hFFFE) begin n_fail++; $display("FAIL blank_digit0 got=%h want=fffe", qa[0].word); end
  endtask

  task automatic test_protocol();
    n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL str_clk_overlap got=%0d want=0", overlap); end
    n_checks++; if (glitch != 0) begin n_fail++; $display("FAIL dat_change_in_hi got=%0d want=0", glitch); end
  endtask

  initial begin
    test_reset();
    test_first_strobe();
    test_lzs();
    test_random();
    test_snapshot();
    test_reset_mid();
    test_period();
    test_enable();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
